// File: rtl/hsid_pkg.sv
// Shared HSID parameters, scheduler state encoding and helpers.
// Imported by the library scheduler and its arg-min sub-block.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH       = 32;
    localparam int HSID_DATA_WIDTH       = 16;
    localparam int HSID_HSI_BANDS        = 8;
    localparam int HSID_HSI_LIBRARY_SIZE = 8;

    localparam logic [HSID_WORD_WIDTH-1:0] HSID_MSE_MAX = '1;

    typedef enum logic [1:0] {
        HSID_SCHED_IDLE,
        HSID_SCHED_FETCH,
        HSID_SCHED_DRAIN,
        HSID_SCHED_FINISH
    } hsid_sched_state_t;

    // Address width that never collapses to zero bits.
    function automatic int hsid_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mse_argmin.sv
// Running strict-less-than minimum over (value, ref) pairs.
// Equal values keep the earlier entry; clear restarts the search.
module mse_argmin
    import hsid_pkg::*;
#(
    parameter int VALUE_WIDTH = HSID_WORD_WIDTH,
    parameter int REF_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic [REF_WIDTH-1:0]   in_ref,
    output logic [VALUE_WIDTH-1:0] best_value,
    output logic [REF_WIDTH-1:0]   best_ref
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_value <= '1;
            best_ref   <= '0;
        end else if (clear) begin
            best_value <= '1;
            best_ref   <= '0;
        end else if (in_valid && (in_value < best_value)) begin
            best_value <= in_value;
            best_ref   <= in_ref;
        end
    end

endmodule

// File: rtl/mse_lib_sched.sv
// Streams one pixel vector against each library reference into mse_reg
// and tracks the best-matching reference from the returned MSE values.
module mse_lib_sched
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
    parameter int DATA_WIDTH       = HSID_DATA_WIDTH,
    parameter int HSI_BANDS        = HSID_HSI_BANDS,
    parameter int HSI_LIBRARY_SIZE = HSID_HSI_LIBRARY_SIZE,
    localparam int DATA_PER_WORD   = WORD_WIDTH / DATA_WIDTH,
    localparam int ELEMENTS        = HSI_BANDS / DATA_PER_WORD,
    localparam int LIB_ADDR        = hsid_clog2_min1(HSI_LIBRARY_SIZE),
    localparam int EL_ADDR         = hsid_clog2_min1(ELEMENTS),
    localparam int MEM_ADDR        = hsid_clog2_min1(HSI_LIBRARY_SIZE * ELEMENTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LIB_ADDR:0]     library_size,
    output logic [EL_ADDR-1:0]    pxl_addr,
    output logic [MEM_ADDR-1:0]   lib_addr,
    output logic                  mem_rd_en,
    input  logic [WORD_WIDTH-1:0] pxl_rdata,
    input  logic [WORD_WIDTH-1:0] lib_rdata,
    output logic [WORD_WIDTH-1:0] element_a,
    output logic [WORD_WIDTH-1:0] element_b,
    output logic                  element_valid,
    output logic                  element_start,
    output logic                  element_last,
    output logic [LIB_ADDR-1:0]   vctr_ref,
    input  logic [WORD_WIDTH-1:0] mse_value,
    input  logic [LIB_ADDR-1:0]   mse_ref,
    input  logic                  mse_valid,
    output logic                  busy,
    output logic                  done,
    output logic [LIB_ADDR-1:0]   best_ref,
    output logic [WORD_WIDTH-1:0] best_mse
);

    localparam int LW = LIB_ADDR + 1;
    localparam logic [LW-1:0]      LIB_MAX = LW'(HSI_LIBRARY_SIZE);
    localparam logic [EL_ADDR-1:0] EL_LAST = EL_ADDR'(ELEMENTS - 1);

    hsid_sched_state_t state_q, state_d;

    logic [LW-1:0]       size_q;
    logic [LW-1:0]       size_in;
    logic [LW-1:0]       cnt_q;
    logic [LIB_ADDR-1:0] ref_q;
    logic [EL_ADDR-1:0]  j_q;
    logic [MEM_ADDR-1:0] addr_q;
    logic                done_q;
    logic                start_acc;
    logic                acc_valid;
    logic                last_el;
    logic                fetch_end;

    assign start_acc = start && !busy;
    assign size_in   = (library_size > LIB_MAX) ? LIB_MAX : library_size;
    assign last_el   = (j_q == EL_LAST);
    assign fetch_end = last_el && ({1'b0, ref_q} == size_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HSID_SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        acc_valid = 1'b0;
        unique case (state_q)
            HSID_SCHED_IDLE: begin
                if (start_acc) begin
                    state_d = (size_in == '0) ? HSID_SCHED_FINISH
                                              : HSID_SCHED_FETCH;
                end
            end
            HSID_SCHED_FETCH: begin
                mem_rd_en = 1'b1;
                acc_valid = mse_valid;
                if (fetch_end) begin
                    state_d = HSID_SCHED_DRAIN;
                end
            end
            HSID_SCHED_DRAIN: begin
                acc_valid = mse_valid;
                if (cnt_q == size_q) begin
                    state_d = HSID_SCHED_FINISH;
                end
            end
            HSID_SCHED_FINISH: begin
                state_d = HSID_SCHED_IDLE;
            end
            default: begin
                state_d = HSID_SCHED_IDLE;
            end
        endcase
    end

    // j runs fastest; lib_addr is tracked as a running count instead of ref*ELEMENTS+j
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            size_q <= '0;
            cnt_q  <= '0;
            ref_q  <= '0;
            j_q    <= '0;
            addr_q <= '0;
        end else if (start_acc) begin
            size_q <= size_in;
            cnt_q  <= '0;
            ref_q  <= '0;
            j_q    <= '0;
            addr_q <= '0;
        end else begin
            if (mem_rd_en) begin
                addr_q <= fetch_end ? '0 : addr_q + 1'b1;
                if (last_el) begin
                    j_q   <= '0;
                    ref_q <= fetch_end ? '0 : ref_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end
            if (acc_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            element_valid <= 1'b0;
            element_start <= 1'b0;
            element_last  <= 1'b0;
            vctr_ref      <= '0;
            done_q        <= 1'b0;
        end else begin
            element_valid <= mem_rd_en;
            element_start <= mem_rd_en && (j_q == '0);
            element_last  <= mem_rd_en && last_el;
            if (mem_rd_en) begin
                vctr_ref <= ref_q;
            end
            done_q <= (state_q == HSID_SCHED_FINISH);
        end
    end

    // RAM data lands in the same cycle as the registered control
    assign element_a = element_valid ? pxl_rdata : '0;
    assign element_b = element_valid ? lib_rdata : '0;
    assign pxl_addr  = j_q;
    assign lib_addr  = addr_q;
    assign done      = done_q;
    assign busy      = (state_q != HSID_SCHED_IDLE) || done_q;

    mse_argmin #(
        .VALUE_WIDTH (WORD_WIDTH),
        .REF_WIDTH   (LIB_ADDR)
    ) u_argmin (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .in_valid   (acc_valid),
        .in_value   (mse_value),
        .in_ref     (mse_ref),
        .best_value (best_mse),
        .best_ref   (best_ref)
    );

endmodule
